mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports req_valid[1:0], req_op[3:0], req_a[63:0], req_b[63:0], inputs; per requester i: request flag, op in bits [2i+1:2i], operand A in bits [32i+31:32i], operand B in bits [32i+31:32i].
REQ-004 SHALL have port req_ready[1:0], output, 2, one-cycle accept pulse per requester.
REQ-005 SHALL have ports resp_valid[1:0] (output, 2, one-cycle result pulse per requester) and resp_data (output, 32, result).
REQ-006 SHALL have ports flush (input, 1, invalidate result cache) and busy (output, 1, high in any state other than IDLE).
REQ-007 SHALL have multiplier-side ports mul_start (output, 1), mul_multiplicand (output, 32), mul_multiplier (output, 32), mul_is_signed (output, 2), mul_finished (input, 1) and mul_product (input, 64).

Function
REQ-008 SHALL decode op as follows: 00 MUL returns product[31:0] with is_signed 2'b11; 01 MULH returns [63:32] with 2'b11; 10 MULHSU returns [63:32] with 2'b10 (A signed, B unsigned); 11 MULHU returns [63:32] with 2'b00.
REQ-009 SHALL drive mul_multiplicand from A and mul_multiplier from B; is_signed[1] SHALL qualify A and is_signed[0] SHALL qualify B.
REQ-010 SHALL implement FSM states IDLE, START, WAIT, CAPTURE and RESP.
REQ-011 SHALL accept requests only in IDLE; at most one req_ready bit SHALL be high in any cycle.
REQ-012 SHALL latch the op, A, B and granted index into internal registers on accept.
REQ-013 SHALL arbitrate round-robin; when both requesters are valid, it SHALL grant the rr pointer (reset 0); after each grant the pointer SHALL move to the non-granted index.
REQ-014 SHALL treat a lone valid requester as granted regardless of the pointer.
REQ-015 SHALL register a cache entry: valid bit, A, B, is_signed and the 64-bit product.
REQ-016 SHALL count a hit when the entry is valid, A and B match, and either the op is MUL or is_signed matches; a hit in IDLE SHALL go to RESP next cycle with no mul_start.
REQ-017 SHALL go IDLE->START on a miss; START SHALL assert mul_start for exactly one cycle with operands and is_signed valid, then go to WAIT.
REQ-018 SHALL hold WAIT until mul_finished=1, then go to CAPTURE; CAPTURE SHALL latch mul_product into the cache, set valid, and go to RESP.
REQ-019 SHALL, in RESP, pulse resp_valid[granted] for one cycle with the selected half in resp_data, then return to IDLE.
REQ-020 SHALL drive resp_data to 0 whenever resp_valid is 0.
REQ-021 SHALL give a miss latency from accept cycle T of: mul_start at T+1, CAPTURE at cycle F+1 where F is the mul_finished cycle, resp_valid at F+2.
REQ-022 SHALL give a hit latency of resp_valid at T+1.
REQ-023 SHALL drive mul operand and is_signed outputs from the latched request registers in all states, holding them stable through WAIT.
REQ-024 SHALL clear the cache valid bit on flush in any state; a simultaneous CAPTURE SHALL take priority and leave the bit set.
REQ-025 SHALL ignore mul_finished outside WAIT.

Reset
REQ-026 SHALL, on nRST=0 at any time including mid-operation, force IDLE, rr pointer 0, cache valid 0, and req_ready, resp_valid, resp_data, mul_start, busy, mul_is_signed and mul operands all 0.
REQ-027 SHALL emit no response for a request in flight at reset.

Verification
REQ-028 SHALL cover: port0 MUL A=7, B=6 -> resp_valid[0] with resp_data=0x0000002A; exactly one mul_start.
REQ-029 SHALL cover: MULH A=B=0xFFFFFFFF -> 0x00000000; then flush and MULHU with the same operands -> 0xFFFFFFFE.
REQ-030 SHALL cover: both ports valid in the same cycle after reset -> port0 granted first; port1 is granted on the next return to IDLE and responds after port0.
REQ-031 SHALL cover: MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF; then MUL with the same operands -> 0xFFFFFFFE at T+1 with mul_start low (hit).
REQ-032 SHALL cover: nRST pulsed while in WAIT -> all outputs 0 and no resp_valid; a following MUL A=3, B=5 -> 0x0000000F.
REQ-033 SHALL cover: flush asserted in IDLE, then a repeat of the cached request -> miss with mul_start asserted.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-port round-robin front end for a shared 32x32 multiplier.
// Decodes MUL/MULH/MULHSU/MULHU, keeps a single-entry result cache so a
// repeated operand pair answers without restarting the multiplier, and
// returns the selected product half to the requester that was granted.
// All outputs come from flops; req_ready pulses in the cycle after the
// accept edge, alongside mul_start (miss) or resp_valid (hit).

module mul_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  req_valid,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    input  logic        flush,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_multiplicand,
    output logic [31:0] mul_multiplier,
    output logic [1:0]  mul_is_signed,
    input  logic        mul_finished,
    input  logic [63:0] mul_product
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Operand signedness for an op: bit 1 qualifies A, bit 0 qualifies B.
    function automatic logic [1:0] op_signedness(input logic [1:0] op);
        logic [1:0] sgn;
        case (op)
            2'b00:   sgn = 2'b11;
            2'b01:   sgn = 2'b11;
            2'b10:   sgn = 2'b10;
            2'b11:   sgn = 2'b00;
            default: sgn = 2'b00;
        endcase
        return sgn;
    endfunction

    // MUL returns the low word, every other op the high word.
    function automatic logic [31:0] select_half(input logic [1:0] op, input logic [63:0] product);
        logic [31:0] half;
        if (op == 2'b00) begin
            half = product[31:0];
        end else begin
            half = product[63:32];
        end
        return half;
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic        rr_ptr_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [1:0]  sgn_r;
    logic        gnt_r;

    logic        cache_valid_r;
    logic [31:0] cache_a_r;
    logic [31:0] cache_b_r;
    logic [1:0]  cache_sgn_r;
    logic [63:0] cache_prod_r;

    logic [1:0]  req_ready_r;
    logic [1:0]  resp_valid_r;
    logic [31:0] resp_data_r;
    logic        busy_r;
    logic        mul_start_r;

    logic        gnt_idx_s;
    logic        accept_s;
    logic [1:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [1:0]  sel_sgn_s;
    logic        hit_s;
    logic        resp_port_s;
    logic [31:0] resp_data_s;

    // Arbitration, request selection and cache lookup for the IDLE accept.
    always_comb begin
        gnt_idx_s = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_idx_s = rr_ptr_r;
        end else if (req_valid[1]) begin
            gnt_idx_s = 1'b1;
        end else begin
            gnt_idx_s = 1'b0;
        end
        accept_s  = (state_r == IDLE) && (req_valid != 2'b00);
        sel_op_s  = gnt_idx_s ? req_op[3:2]  : req_op[1:0];
        sel_a_s   = gnt_idx_s ? req_a[63:32] : req_a[31:0];
        sel_b_s   = gnt_idx_s ? req_b[63:32] : req_b[31:0];
        sel_sgn_s = op_signedness(sel_op_s);
        // A same-cycle flush already counts as invalidating the entry.
        hit_s     = cache_valid_r && !flush &&
                    (sel_a_s == cache_a_r) && (sel_b_s == cache_b_r) &&
                    ((sel_op_s == 2'b00) || (sel_sgn_s == cache_sgn_r));
    end

    // Next-state decode for the request sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = hit_s ? RESP : START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                if (mul_finished) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            CAPTURE: begin
                next_state_s = RESP;
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Response port and data to be registered for the RESP cycle; a hit reads
    // the cache, a miss forwards the product being captured this cycle.
    always_comb begin
        resp_port_s = gnt_r;
        resp_data_s = 32'd0;
        if (next_state_s == RESP) begin
            if (state_r == IDLE) begin
                resp_port_s = gnt_idx_s;
                resp_data_s = select_half(sel_op_s, cache_prod_r);
            end else begin
                resp_port_s = gnt_r;
                resp_data_s = select_half(op_r, mul_product);
            end
        end else begin
            resp_port_s = gnt_r;
            resp_data_s = 32'd0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the granted request and advance the round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_r     <= 2'b00;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            sgn_r    <= 2'b00;
            gnt_r    <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else if (accept_s) begin
            op_r     <= sel_op_s;
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            sgn_r    <= sel_sgn_s;
            gnt_r    <= gnt_idx_s;
            rr_ptr_r <= ~gnt_idx_s;
        end
    end

    // Single-entry result cache; a capture wins over a concurrent flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cache_valid_r <= 1'b0;
            cache_a_r     <= 32'd0;
            cache_b_r     <= 32'd0;
            cache_sgn_r   <= 2'b00;
            cache_prod_r  <= 64'd0;
        end else if (state_r == CAPTURE) begin
            cache_valid_r <= 1'b1;
            cache_a_r     <= a_r;
            cache_b_r     <= b_r;
            cache_sgn_r   <= sgn_r;
            cache_prod_r  <= mul_product;
        end else if (flush) begin
            cache_valid_r <= 1'b0;
        end
    end

    // Registered handshake, response and multiplier control outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_ready_r  <= 2'b00;
            resp_valid_r <= 2'b00;
            resp_data_r  <= 32'd0;
            busy_r       <= 1'b0;
            mul_start_r  <= 1'b0;
        end else begin
            req_ready_r  <= accept_s ? (gnt_idx_s ? 2'b10 : 2'b01) : 2'b00;
            resp_valid_r <= (next_state_s == RESP) ? (resp_port_s ? 2'b10 : 2'b01) : 2'b00;
            resp_data_r  <= resp_data_s;
            busy_r       <= (next_state_s != IDLE);
            mul_start_r  <= (next_state_s == START);
        end
    end

    assign req_ready        = req_ready_r;
    assign resp_valid       = resp_valid_r;
    assign resp_data        = resp_data_r;
    assign busy             = busy_r;
    assign mul_start        = mul_start_r;
    assign mul_multiplicand = a_r;
    assign mul_multiplier   = b_r;
    assign mul_is_signed    = sgn_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench for mul_arbiter with a small multiplier
// model that answers mul_start two cycles later.

module tb_mul_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        flush;
    logic        busy;
    logic        mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [1:0]  mul_is_signed;
    logic        mul_finished;
    logic [63:0] mul_product;

    int checks   = 0;
    int failures = 0;
    int plan_k   = 0;

    mul_arbiter dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .req_valid        (req_valid),
        .req_op           (req_op),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .flush            (flush),
        .busy             (busy),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_is_signed    (mul_is_signed),
        .mul_finished     (mul_finished),
        .mul_product      (mul_product)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s[1] ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s[0] ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Multiplier model step, called once per negedge with the cycle index k.
    task automatic mul_step(input int k);
        if (mul_start && plan_k == 0) begin
            plan_k = k + 2;
        end
        if (plan_k != 0 && k == plan_k) begin
            mul_product  = model_mul(mul_multiplicand, mul_multiplier, mul_is_signed);
            mul_finished = 1'b1;
        end else if (plan_k != 0 && k == plan_k + 1) begin
            mul_finished = 1'b0;
            plan_k       = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST         = 1'b0;
        req_valid    = 2'b00;
        flush        = 1'b0;
        mul_finished = 1'b0;
        plan_k       = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic pulse_flush();
        @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
    endtask

    // One request from a lone requester; checks handshake, latency and data.
    task automatic do_req(input string name, input int port, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input logic exp_hit,
                          input logic [1:0] exp_sgn);
        int          ready_k;
        int          resp_k;
        int          resp_cnt;
        int          starts;
        logic [1:0]  ready_v;
        logic [1:0]  resp_v;
        logic [31:0] data_v;
        logic [1:0]  sgn_v;
        logic [31:0] mc_v;
        logic [31:0] mp_v;
        logic        busy2;
        logic        idle_err;
        logic [1:0]  exp_oh;
        ready_k  = 0;
        resp_k   = 0;
        resp_cnt = 0;
        starts   = 0;
        ready_v  = 2'b00;
        resp_v   = 2'b00;
        data_v   = 32'd0;
        sgn_v    = 2'b00;
        mc_v     = 32'd0;
        mp_v     = 32'd0;
        busy2    = 1'b0;
        idle_err = 1'b0;
        exp_oh   = (port == 1) ? 2'b10 : 2'b01;
        @(negedge CLK);
        req_valid[port]        = 1'b1;
        req_op[2*port +: 2]    = op;
        req_a[32*port +: 32]   = a;
        req_b[32*port +: 32]   = b;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (req_ready != 2'b00 && ready_k == 0) begin
                ready_k         = k;
                ready_v         = req_ready;
                req_valid[port] = 1'b0;
            end
            if (mul_start) begin
                starts++;
                sgn_v = mul_is_signed;
                mc_v  = mul_multiplicand;
                mp_v  = mul_multiplier;
            end
            if (k == 2) busy2 = busy;
            if (resp_valid != 2'b00) begin
                resp_cnt++;
                if (resp_k == 0) begin
                    resp_k = k;
                    resp_v = resp_valid;
                    data_v = resp_data;
                end
            end
            if (resp_valid == 2'b00 && resp_data != 32'd0) idle_err = 1'b1;
            mul_step(k);
        end
        checks++; if (ready_k !== 1) begin failures++; $display("FAIL %s ready_cycle: got %0d expected 1", name, ready_k); end
        checks++; if (ready_v !== exp_oh) begin failures++; $display("FAIL %s ready_bits: got %b expected %b", name, ready_v, exp_oh); end
        checks++; if (resp_k !== (exp_hit ? 1 : 5)) begin failures++; $display("FAIL %s resp_cycle: got %0d expected %0d", name, resp_k, exp_hit ? 1 : 5); end
        checks++; if (resp_cnt !== 1) begin failures++; $display("FAIL %s resp_count: got %0d expected 1", name, resp_cnt); end
        checks++; if (resp_v !== exp_oh) begin failures++; $display("FAIL %s resp_port: got %b expected %b", name, resp_v, exp_oh); end
        checks++; if (data_v !== exp_data) begin failures++; $display("FAIL %s resp_data: got %h expected %h", name, data_v, exp_data); end
        checks++; if (starts !== (exp_hit ? 0 : 1)) begin failures++; $display("FAIL %s mul_start_count: got %0d expected %0d", name, starts, exp_hit ? 0 : 1); end
        checks++; if (idle_err !== 1'b0) begin failures++; $display("FAIL %s resp_data_when_idle: got nonzero expected 0", name); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after: got %b expected 0", name, busy); end
        if (!exp_hit) begin
            checks++; if (sgn_v !== exp_sgn) begin failures++; $display("FAIL %s is_signed: got %b expected %b", name, sgn_v, exp_sgn); end
            checks++; if (mc_v !== a || mp_v !== b) begin failures++; $display("FAIL %s operands: got %h,%h expected %h,%h", name, mc_v, mp_v, a, b); end
            checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL %s busy_in_flight: got %b expected 1", name, busy2); end
        end
    endtask

    task automatic test_reset();
        logic [103:0] outs;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        outs = {req_ready, resp_valid, resp_data, mul_start, busy, mul_is_signed,
                mul_multiplicand, mul_multiplier};
        checks++; if (outs !== 104'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL reset_idle: got busy=%b ready=%b expected 0,00", busy, req_ready); end
    endtask

    task automatic test_mul_basic();
        do_req("mul_7x6", 0, 2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0, 2'b11);
    endtask

    task automatic test_mulh_flush();
        do_req("mulh_ff", 1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2'b11);
        pulse_flush();
        do_req("mulhu_ff", 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2'b00);
    endtask

    task automatic test_round_robin();
        int          r0k;
        int          r1k;
        int          p0k;
        int          p1k;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        both_err;
        r0k = 0; r1k = 0; p0k = 0; p1k = 0;
        d0 = 32'd0; d1 = 32'd0; both_err = 1'b0;
        apply_reset();
        @(negedge CLK);
        req_op    = 4'b0000;
        req_a     = {32'd4, 32'd2};
        req_b     = {32'd5, 32'd3};
        req_valid = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (req_ready == 2'b11) both_err = 1'b1;
            if (req_ready[0] && r0k == 0) begin r0k = k; req_valid[0] = 1'b0; end
            if (req_ready[1] && r1k == 0) begin r1k = k; req_valid[1] = 1'b0; end
            if (resp_valid[0] && p0k == 0) begin p0k = k; d0 = resp_data; end
            if (resp_valid[1] && p1k == 0) begin p1k = k; d1 = resp_data; end
            mul_step(k);
        end
        checks++; if (both_err !== 1'b0) begin failures++; $display("FAIL rr_one_ready: got both expected one"); end
        checks++; if (r0k !== 1) begin failures++; $display("FAIL rr_port0_ready: got %0d expected 1", r0k); end
        checks++; if (r1k !== 7) begin failures++; $display("FAIL rr_port1_ready: got %0d expected 7", r1k); end
        checks++; if (p0k !== 5) begin failures++; $display("FAIL rr_port0_resp: got %0d expected 5", p0k); end
        checks++; if (p1k !== 11) begin failures++; $display("FAIL rr_port1_resp: got %0d expected 11", p1k); end
        checks++; if (d0 !== 32'h00000006) begin failures++; $display("FAIL rr_port0_data: got %h expected 00000006", d0); end
        checks++; if (d1 !== 32'h00000014) begin failures++; $display("FAIL rr_port1_data: got %h expected 00000014", d1); end
    endtask

    task automatic test_cache_hit();
        do_req("mulhsu", 0, 2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 2'b10);
        do_req("mul_hit", 1, 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 2'b11);
    endtask

    task automatic test_flush_idle();
        pulse_flush();
        do_req("flush_miss", 0, 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 2'b11);
        do_req("refill_hit", 1, 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 2'b11);
    endtask

    task automatic test_reset_mid();
        logic [103:0] outs;
        logic         resp_seen;
        resp_seen = 1'b0;
        @(negedge CLK);
        req_valid[0] = 1'b1;
        req_op[1:0]  = 2'b00;
        req_a[31:0]  = 32'd9;
        req_b[31:0]  = 32'd9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            if (req_ready[0]) req_valid[0] = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_wait: got %b expected 1", busy); end
        nRST = 1'b0;
        #1;
        outs = {req_ready, resp_valid, resp_data, mul_start, busy, mul_is_signed,
                mul_multiplicand, mul_multiplier};
        checks++; if (outs !== 104'd0) begin failures++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (resp_valid != 2'b00) resp_seen = 1'b1;
        end
        checks++; if (resp_seen !== 1'b0) begin failures++; $display("FAIL midrst_no_resp: got 1 expected 0"); end
        do_req("mul_3x5", 0, 2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b0, 2'b11);
    endtask

    initial begin
        nRST         = 1'b0;
        req_valid    = 2'b00;
        req_op       = 4'b0000;
        req_a        = 64'd0;
        req_b        = 64'd0;
        flush        = 1'b0;
        mul_finished = 1'b0;
        mul_product  = 64'd0;
        test_reset();
        test_mul_basic();
        test_mulh_flush();
        test_round_robin();
        test_cache_hit();
        test_flush_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
